// File: rtl/apb4_master_bridge.sv
// apb4_master_bridge: valid/ready command stream to APB4 SETUP/ACCESS transfers, with a wait-state timeout
module apb4_master_bridge #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [ADDR_WIDTH-1:0]    req_addr_i,
  input  logic                     req_write_i,
  input  logic [DATA_WIDTH-1:0]    req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]  req_wstrb_i,
  input  logic [2:0]               req_prot_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [DATA_WIDTH-1:0]    rsp_rdata_o,
  output logic                     rsp_err_o,
  output logic                     rsp_timeout_o,
  input  logic [TIMEOUT_WIDTH-1:0] timeout_val_i,
  output logic                     busy_o,
  output logic [ADDR_WIDTH-1:0]    paddr_o,
  output logic                     psel_o,
  output logic                     penable_o,
  output logic                     pwrite_o,
  output logic [2:0]               pprot_o,
  output logic [DATA_WIDTH-1:0]    pwdata_o,
  output logic [DATA_WIDTH/8-1:0]  pstrb_o,
  input  logic [DATA_WIDTH-1:0]    prdata_i,
  input  logic                     pready_i,
  input  logic                     pslverr_i
);
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;
  state_t                   r_state;
  logic [TIMEOUT_WIDTH-1:0] r_cnt;
  logic                     w_tmo;
  assign w_tmo       = (timeout_val_i != '0) && (r_cnt == timeout_val_i) && !pready_i;
  // Gated by reset so the command port is closed while reset is held
  assign req_ready_o = rst_n_i && (r_state == S_IDLE);
  assign busy_o      = r_state != S_IDLE;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      paddr_o       <= '0;
      psel_o        <= 1'b0;
      penable_o     <= 1'b0;
      pwrite_o      <= 1'b0;
      pprot_o       <= '0;
      pwdata_o      <= '0;
      pstrb_o       <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid_i) begin
          r_state  <= S_SETUP;
          r_cnt    <= '0;
          psel_o   <= 1'b1;
          paddr_o  <= req_addr_i;
          pwrite_o <= req_write_i;
          pprot_o  <= req_prot_i;
          pwdata_o <= req_write_i ? req_wdata_i : '0;
          pstrb_o  <= req_write_i ? req_wstrb_i : '0;
        end
        S_SETUP: begin
          r_state   <= S_ACCESS;
          penable_o <= 1'b1;
        end
        S_ACCESS: if (pready_i || w_tmo) begin
          r_state       <= S_RESP;
          psel_o        <= 1'b0;
          penable_o     <= 1'b0;
          rsp_valid_o   <= 1'b1;
          rsp_rdata_o   <= (pready_i && !pwrite_o) ? prdata_i : '0;
          rsp_err_o     <= pready_i ? pslverr_i : 1'b1;
          rsp_timeout_o <= !pready_i;
        end else if (r_cnt != '1) begin
          r_cnt <= r_cnt + 1'b1;
        end
        S_RESP: if (rsp_ready_i) begin
          r_state     <= S_IDLE;
          rsp_valid_o <= 1'b0;
        end
      endcase
    end
  end
endmodule
